// File: rtl/dfr_reservoir_core.sv
// Delay-feedback reservoir: a shift chain of virtual nodes fed through an external activation RAM.
// Optional build macro DFR_SATURATE_EN clamps out-of-range RAM addresses to all ones.
module dfr_reservoir_core #(
  parameter int unsigned NUM_VIRTUAL_NODES = 10,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ACT_ADDR_WIDTH    = 16,
  parameter int unsigned ACT_DATA_WIDTH    = 12,
  parameter int unsigned FB_SHIFT          = 3,
  parameter int unsigned RAM_LATENCY       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  output logic                      act_rd_en,
  input  logic [ACT_DATA_WIDTH-1:0] act_data,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid
);

  localparam int unsigned CW = $clog2(RAM_LATENCY + 1);
  localparam int unsigned FW = DATA_WIDTH + ACT_DATA_WIDTH + FB_SHIFT;
  localparam logic [CW-1:0] Lat = CW'(RAM_LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ACT_DATA_WIDTH-1:0] node_q [NUM_VIRTUAL_NODES];
  logic [ACT_ADDR_WIDTH-1:0] act_addr_q, act_addr_d, next_addr;
  logic                      rd_en_q, rd_en_d, dv_q, dv_d;
  logic                      accept, do_shift;
  logic [FW-1:0]             fb_wide;
  logic [DATA_WIDTH-1:0]     fb;
  logic [DATA_WIDTH:0]       sum;
  logic                      unused_bits;

  // Feedback and dout share the same truncated, shifted view of the last node.
  assign fb_wide = FW'(node_q[NUM_VIRTUAL_NODES-1]) << FB_SHIFT;
  assign fb      = fb_wide[DATA_WIDTH-1:0];
  assign sum     = {1'b0, din} + {1'b0, fb};

`ifdef DFR_SATURATE_EN
  assign next_addr   = (|sum[DATA_WIDTH:ACT_ADDR_WIDTH]) ? '1 : sum[ACT_ADDR_WIDTH-1:0];
  assign unused_bits = ^fb_wide[FW-1:DATA_WIDTH];
`else
  assign next_addr   = sum[ACT_ADDR_WIDTH-1:0];
  assign unused_bits = ^{fb_wide[FW-1:DATA_WIDTH], sum[DATA_WIDTH:ACT_ADDR_WIDTH]};
`endif

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid & in_ready & ~clear;
  assign act_addr   = act_addr_q;
  assign act_rd_en  = rd_en_q;
  assign dout_valid = dv_q;
  assign dout       = fb;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_addr_d = act_addr_q;
    rd_en_d    = 1'b0;
    dv_d       = 1'b0;
    do_shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          act_addr_d = next_addr;
          rd_en_d    = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (cnt_q != Lat) cnt_d = cnt_q + 1'b1;
        if (cnt_q == Lat - 1'b1) state_d = StShift;
      end
      StShift: begin
        do_shift = 1'b1;
        dv_d     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear aborts any in-flight update, including a shift due this edge.
    if (clear) begin
      state_d  = StIdle;
      cnt_d    = '0;
      rd_en_d  = 1'b0;
      dv_d     = 1'b0;
      do_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      act_addr_q <= '0;
      rd_en_q    <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_addr_q <= act_addr_d;
      rd_en_q    <= rd_en_d;
      dv_q       <= dv_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) node_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) node_q[i] <= '0;
    end else if (do_shift) begin
      node_q[0] <= act_data;
      for (int i = 1; i < NUM_VIRTUAL_NODES; i++) node_q[i] <= node_q[i-1];
    end
  end

endmodule

// File: tb/tb_dfr_reservoir_core.sv
// Bench for dfr_reservoir_core: a default instance (10 nodes, latency 2) and a small one
// (2 nodes, latency 1), each with a pipelined RAM model returning addr[11:0].
module tb_dfr_reservoir_core;
  localparam int NA = 10, LA = 2, NB = 2, LB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_clear, a_valid, a_ready, a_rd_en, a_dv;
  logic [31:0] a_din, a_dout;
  logic [15:0] a_addr;
  logic [11:0] a_data;
  logic        b_clear, b_valid, b_ready, b_rd_en, b_dv;
  logic [31:0] b_din, b_dout;
  logic [15:0] b_addr;
  logic [11:0] b_data;

  dfr_reservoir_core dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_ready(a_ready),
    .din(a_din), .act_addr(a_addr), .act_rd_en(a_rd_en), .act_data(a_data),
    .dout(a_dout), .dout_valid(a_dv)
  );

  dfr_reservoir_core #(.NUM_VIRTUAL_NODES(NB), .RAM_LATENCY(LB)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_ready(b_ready),
    .din(b_din), .act_addr(b_addr), .act_rd_en(b_rd_en), .act_data(b_data),
    .dout(b_dout), .dout_valid(b_dv)
  );

  // RAM models: capture address on the read strobe, then delay through the pipeline
  logic [11:0] pa [LA];
  logic [11:0] pb;
  always_ff @(posedge clk) begin
    if (a_rd_en) pa[0] <= a_addr[11:0];
    for (int k = 1; k < LA; k++) pa[k] <= pa[k-1];
    if (b_rd_en) pb <= b_addr[11:0];
  end
  assign a_data = pa[LA-1];
  assign b_data = pb;

  // Selected instance view so one set of tasks serves both
  bit          sel;
  logic        o_ready, o_rd_en, o_dv;
  logic [15:0] o_addr;
  logic [31:0] o_dout;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_rd_en = sel ? b_rd_en : a_rd_en;
  assign o_dv    = sel ? b_dv    : a_dv;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_dout  = sel ? b_dout  : a_dout;

  // Reference model: node i = i-th most recent activation value
  logic [11:0] ma[$];
  logic [11:0] mb[$];

  function automatic int lat();
    return sel ? LB : LA;
  endfunction

  function automatic logic [11:0] model_last();
    return sel ? mb[NB-1] : ma[NA-1];
  endfunction

  function automatic void model_push(input logic [11:0] d);
    if (sel) begin mb.push_front(d); void'(mb.pop_back()); end
    else     begin ma.push_front(d); void'(ma.pop_back()); end
  endfunction

  function automatic void model_zero(input bit both);
    if (both || !sel) begin ma = {}; repeat (NA) ma.push_back(12'h0); end
    if (both || sel)  begin mb = {}; repeat (NB) mb.push_back(12'h0); end
  endfunction

  function automatic logic [15:0] exp_addr(input logic [31:0] d, input logic [11:0] last);
    logic [32:0] s;
    s = {1'b0, d} + {1'b0, 32'(last) << 3};
`ifdef DFR_SATURATE_EN
    if (s >= 33'h1_0000) return 16'hFFFF;
`endif
    return s[15:0];
  endfunction

  function automatic logic [11:0] dut_node0();
    return sel ? dut_b.node_q[0] : dut_a.node_q[0];
  endfunction

  function automatic bit nodes_zero();
    for (int i = 0; i < NA; i++) if (dut_a.node_q[i] !== 12'h0) return 1'b0;
    for (int i = 0; i < NB; i++) if (dut_b.node_q[i] !== 12'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    if (sel) begin b_valid = v; b_din = d; b_clear = c; end
    else     begin a_valid = v; a_din = d; a_clear = c; end
  endtask

  // One full transaction with cycle-exact checks; starts and ends just after a negedge
  task automatic send(input logic [31:0] d);
    logic [15:0] ea;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL send_ready: in_ready=%b required 1", o_ready); end
    ea = exp_addr(d, model_last());
    drive(1'b1, d, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, $urandom, 1'b0);
    total++;
    if (o_addr !== ea) begin bad++; $display("FAIL act_addr: got %h required %h", o_addr, ea); end
    total++;
    if (o_rd_en !== 1'b1 || o_ready !== 1'b0) begin
      bad++; $display("FAIL accept_flags: rd_en=%b ready=%b required 1 0", o_rd_en, o_ready);
    end
    for (int k = 0; k < lat(); k++) begin
      @(posedge clk); #1;
      total++;
      if (o_dv !== 1'b0 || o_rd_en !== 1'b0) begin
        bad++; $display("FAIL wait_quiet: dv=%b rd_en=%b at wait cycle %0d", o_dv, o_rd_en, k);
      end
    end
    @(posedge clk); #1;
    model_push(ea[11:0]);
    total++;
    if (o_dv !== 1'b1 || o_ready !== 1'b1) begin
      bad++; $display("FAIL shift_flags: dv=%b ready=%b required 1 1", o_dv, o_ready);
    end
    total++;
    if (o_dout !== 32'(model_last()) << 3) begin
      bad++; $display("FAIL dout: got %h required %h", o_dout, 32'(model_last()) << 3);
    end
    total++;
    if (dut_node0() !== ea[11:0]) begin
      bad++; $display("FAIL node0: got %h required %h", dut_node0(), ea[11:0]);
    end
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string name);
    total++;
    if (a_dout !== 32'h0 || a_dv !== 1'b0 || a_rd_en !== 1'b0 || a_ready !== 1'b1 ||
        b_dout !== 32'h0 || b_dv !== 1'b0 || b_rd_en !== 1'b0 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: a dout=%h dv=%b rd=%b rdy=%b b dout=%h dv=%b rd=%b rdy=%b required 0 0 0 1",
               name, a_dout, a_dv, a_rd_en, a_ready, b_dout, b_dv, b_rd_en, b_ready);
    end
    total++;
    if (!nodes_zero()) begin bad++; $display("FAIL %s_nodes: nodes not all zero, required zero", name); end
  endtask

  task automatic test_reset();
    check_idle_zero("reset_state");
    total++;
    if (a_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h required 0000", a_addr); end
  endtask

  task automatic test_single();
    sel = 1'b0;
    send(32'h5);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 14; i++) send((i % 2 == 0) ? $urandom : $urandom_range(0, 32'h3_FFFF));
  endtask

  task automatic test_clear_wait();
    sel = 1'b0;
    send($urandom_range(1, 16'h0FFF));
    drive(1'b1, 32'h7, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    model_zero(1'b0);
    total++;
    if (a_ready !== 1'b1 || a_dout !== 32'h0) begin
      bad++; $display("FAIL clear_wait: ready=%b dout=%h required 1 0", a_ready, a_dout);
    end
    total++;
    if (!nodes_zero()) begin bad++; $display("FAIL clear_wait_nodes: nodes not zero, required zero"); end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < LA + 2; k++) begin
      @(posedge clk); #1;
      total++;
      if (a_dv !== 1'b0) begin bad++; $display("FAIL clear_wait_dv: dv=%b required 0 (cycle %0d)", a_dv, k); end
    end
    @(negedge clk);
  endtask

  task automatic test_clear_idle();
    sel = 1'b0;
    send($urandom_range(1, 16'h0FFF));
    drive(1'b1, $urandom, 1'b1);
    @(posedge clk); #1;
    model_zero(1'b0);
    total++;
    if (a_rd_en !== 1'b0 || a_ready !== 1'b1 || a_dout !== 32'h0 || !nodes_zero()) begin
      bad++; $display("FAIL clear_idle: rd_en=%b ready=%b dout=%h required 0 1 0", a_rd_en, a_ready, a_dout);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_sat_wrap();
    sel = 1'b0;
    send(32'h0001_0000);
    send(32'h0001_FFFF);
  endtask

  task automatic test_feedback();
    sel = 1'b1;
    send(32'h10);
    send(32'h0);
    send(32'h0);
    send(32'h0);
    total++;
    if (b_dout !== 32'h0400) begin bad++; $display("FAIL feedback_dout: got %h required 00000400", b_dout); end
  endtask

  // in_valid held high: one accept every lat+2 cycles, addresses tracked by the model
  task automatic test_back_to_back(input bit s, input int n);
    int last_edge, cnt, pending_ok;
    logic [11:0] pending;
    logic [31:0] d;
    logic [15:0] ea;
    sel = s; last_edge = -1; cnt = 0; pending_ok = 0; d = $urandom;
    drive(1'b1, d, 1'b0);
    for (int e = 0; e < n * (lat() + 2); e++) begin
      @(posedge clk); #1;
      if (o_rd_en === 1'b1) begin
        if (pending_ok != 0) model_push(pending);
        ea = exp_addr(d, model_last());
        total++;
        if (o_addr !== ea) begin bad++; $display("FAIL b2b_addr: got %h required %h", o_addr, ea); end
        if (last_edge >= 0) begin
          total++;
          if (e - last_edge != lat() + 2) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles required %0d", e - last_edge, lat() + 2);
          end
        end
        last_edge = e; cnt++; pending = ea[11:0]; pending_ok = 1;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    repeat (lat() + 2) @(posedge clk);
    #1;
    if (pending_ok != 0) model_push(pending);
    total++;
    if (cnt != n) begin bad++; $display("FAIL b2b_count: got %0d accepts required %0d", cnt, n); end
    total++;
    if (o_dout !== 32'(model_last()) << 3 || dut_node0() !== model_last_front()) begin
      bad++; $display("FAIL b2b_final: dout=%h node0=%h required %h %h", o_dout, dut_node0(),
                      32'(model_last()) << 3, model_last_front());
    end
    @(negedge clk);
  endtask

  function automatic logic [11:0] model_last_front();
    return sel ? mb[0] : ma[0];
  endfunction

  task automatic test_reset_mid();
    sel = 1'b0;
    send($urandom_range(1, 16'h0FFF));
    drive(1'b1, 32'h3, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_zero(1'b1);
    total++;
    if (a_dv !== 1'b0 || a_rd_en !== 1'b0 || a_dout !== 32'h0 || a_addr !== 16'h0) begin
      bad++; $display("FAIL reset_async: dv=%b rd_en=%b dout=%h addr=%h required all 0",
                      a_dv, a_rd_en, a_dout, a_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    repeat (LA + 2) @(posedge clk);
    #1;
    total++;
    if (a_dv !== 1'b0 || !nodes_zero()) begin bad++; $display("FAIL reset_no_shift: dv=%b required 0", a_dv); end
    @(negedge clk);
    send(32'h5);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    a_clear = 1'b0; a_valid = 1'b0; a_din = '0;
    b_clear = 1'b0; b_valid = 1'b0; b_din = '0;
    model_zero(1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    test_single();
    test_random();
    test_back_to_back(1'b0, 6);
    test_clear_wait();
    test_clear_idle();
    test_sat_wrap();
    test_feedback();
    test_back_to_back(1'b1, 6);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
